vic_wb_buffer: RTL and testbench

- Write-back buffer directly downstream of the victim cache.
- Captures dirty lines pushed out of the victim queue each cycle and holds them in an age-ordered FIFO.
- Drains the FIFO to memory as BUS_STORE requests over the shared memory port, retrying until memory accepts each one.
- Answers read lookups combinationally so that a miss in both the cache and the victim cache can forward data from a pending write-back.

---
 rtl/vic_wb_buffer_pkg.sv | 38 +++
 rtl/vic_wb_buffer_if.sv | 57 +++++
 rtl/vic_wb_buffer_age_select.sv | 34 +++
 rtl/vic_wb_buffer.sv | 167 ++++++++++++++++
 tb/tb_vic_wb_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vic_wb_buffer_pkg.sv
// Shared definitions for the victim-cache write-back buffer: line and entry
// layouts, memory bus command codes, FSM states and the store-address helper.
package vic_wb_buffer_pkg;

  localparam int NUM_SET_BITS = 4;
  localparam int NUM_TAG_BITS = 12;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [63:0]             data;
  } CACHE_LINE_T;

  typedef struct packed {
    CACHE_LINE_T             line;
    logic [NUM_SET_BITS-1:0] idx;
  } WB_ENTRY_T;

  localparam WB_ENTRY_T EMPTY_WB_ENTRY = '0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    DRAIN_WAIT = 2'd2
  } wb_state_e;

  // Memory address of a buffered line: {zero-extend, tag, idx, 3'b000}
  function automatic logic [63:0] wbAddr(input WB_ENTRY_T entry);
    return {{(64 - NUM_TAG_BITS - NUM_SET_BITS - 3){1'b0}},
            entry.line.tag, entry.idx, 3'b000};
  endfunction

endpackage

// File: rtl/vic_wb_buffer_if.sv
// Bus bundle between the victim cache / memory arbiter and the write-back
// buffer. The buffer uses the slave modport; its environment uses master.
interface vic_wb_buffer_if
  import vic_wb_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IN_PORTS = 3,
  parameter int RD_PORTS = 2
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  CACHE_LINE_T [IN_PORTS-1:0]                    evict_line;
  logic        [IN_PORTS-1:0][NUM_SET_BITS-1:0]  evict_idx;
  logic        [IN_PORTS-1:0]                    evict_valid;

  logic        [RD_PORTS-1:0]                    rd_en;
  logic        [RD_PORTS-1:0][NUM_SET_BITS-1:0]  rd_idx;
  logic        [RD_PORTS-1:0][NUM_TAG_BITS-1:0]  rd_tag;
  logic        [RD_PORTS-1:0][63:0]              rd_data;
  logic        [RD_PORTS-1:0]                    rd_hit;

  logic                                          mem_grant;
  logic        [3:0]                             mem2proc_response;
  logic        [1:0]                             proc2mem_command;
  logic        [63:0]                            proc2mem_addr;
  logic        [63:0]                            proc2mem_data;
  logic                                          wb_req;

  logic        [CNT_W-1:0]                       free_slots;
  logic                                          drain;
  logic                                          drained;
  logic                                          overflow;

  modport slave (
    input  evict_line, evict_idx, evict_valid,
    input  rd_en, rd_idx, rd_tag,
    output rd_data, rd_hit,
    input  mem_grant, mem2proc_response,
    output proc2mem_command, proc2mem_addr, proc2mem_data, wb_req,
    output free_slots,
    input  drain,
    output drained, overflow
  );

  modport master (
    output evict_line, evict_idx, evict_valid,
    output rd_en, rd_idx, rd_tag,
    input  rd_data, rd_hit,
    output mem_grant, mem2proc_response,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, wb_req,
    input  free_slots,
    output drain,
    input  drained, overflow
  );

endinterface

// File: rtl/vic_wb_buffer_age_select.sv
// Picks the youngest matching buffer slot: the hit vector is rotated so bit 0
// is the head (oldest) entry, then the highest set bit wins.
module vic_wb_buffer_age_select #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] hitVec_i,
  input  logic [PTR_W-1:0] head_i,
  output logic             hit_o,
  output logic [PTR_W-1:0] sel_o
);

  logic [DEPTH-1:0] rotated;
  logic [PTR_W-1:0] offset;

  // Rotate the hit vector so that position i is the entry i places after head
  always_comb begin
    rotated = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rotated[i] = hitVec_i[head_i + PTR_W'(i)];
    end
  end

  // Highest rotated position is closest to the tail, i.e. the youngest match
  always_comb begin
    hit_o  = |rotated;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rotated[i]) offset = PTR_W'(i);
    end
    sel_o = head_i + offset;
  end

endmodule

// File: rtl/vic_wb_buffer.sv
// Write-back buffer behind the victim cache: queues dirty evictions in age
// order, drains them to memory as BUS_STORE requests with retry, and lets
// lookups forward data from still-pending write-backs.
module vic_wb_buffer
  import vic_wb_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IN_PORTS = 3,
  parameter int RD_PORTS = 2
) (
  input logic            clock,
  input logic            reset,
  vic_wb_buffer_if.slave bus
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  WB_ENTRY_T        entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_state_e        state_q, state_d;
  logic             overflow_q, overflow_d;

  logic [DEPTH-1:0] wrEn;
  WB_ENTRY_T        wrEntry [DEPTH];
  logic [CNT_W-1:0] acceptCnt;
  logic [CNT_W-1:0] acceptLimit;
  logic [PTR_W-1:0] slotIdx;
  logic             dropSeen;
  logic             issuing;
  logic             pop;

  logic [DEPTH-1:0] hitVec [RD_PORTS];
  logic             selHit [RD_PORTS];
  logic [PTR_W-1:0] selIdx [RD_PORTS];

  // Place dirty candidates at consecutive tail slots up to the free space seen this cycle
  always_comb begin
    wrEn        = '0;
    acceptCnt   = '0;
    dropSeen    = 1'b0;
    slotIdx     = '0;
    acceptLimit = DEPTH_C - count_q;
    for (int s = 0; s < DEPTH; s++) wrEntry[s] = EMPTY_WB_ENTRY;
    for (int p = 0; p < IN_PORTS; p++) begin
      if (bus.evict_valid[p] && bus.evict_line[p].valid && bus.evict_line[p].dirty) begin
        if (acceptCnt < acceptLimit) begin
          slotIdx          = tail_q + acceptCnt[PTR_W-1:0];
          wrEn[slotIdx]    = 1'b1;
          wrEntry[slotIdx] = '{line: bus.evict_line[p], idx: bus.evict_idx[p]};
          acceptCnt        = acceptCnt + CNT_W'(1);
        end else begin
          dropSeen = 1'b1;
        end
      end
    end
  end

  // Issue/pop decision, pointer and counter updates, and FSM next state
  always_comb begin
    state_d    = state_q;
    issuing    = ((state_q == ISSUE) || (state_q == DRAIN_WAIT)) && (count_q != '0);
    pop        = issuing && bus.mem_grant && (bus.mem2proc_response != 4'd0);
    count_d    = count_q + acceptCnt - CNT_W'(pop);
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + acceptCnt[PTR_W-1:0];
    overflow_d = overflow_q | dropSeen;
    if (bus.drain) begin
      state_d = DRAIN_WAIT;
    end else begin
      case (state_q)
        IDLE:       if (count_q != '0) state_d = ISSUE;
        ISSUE:      if (count_d == '0) state_d = IDLE;
        DRAIN_WAIT: if (count_q == '0) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int s = 0; s < DEPTH; s++) begin
        if (wrEn[s]) valid_q[s] <= 1'b1;
      end
      if (pop) valid_q[head_q] <= 1'b0;
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed here
  always_ff @(posedge clock) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (wrEn[s]) entries_q[s] <= wrEntry[s];
    end
  end

  // Memory request and status outputs, forced to their idle values while in reset
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.wb_req           = 1'b0;
    bus.free_slots       = DEPTH_C;
    bus.drained          = 1'b1;
    bus.overflow         = 1'b0;
    if (!reset) begin
      bus.wb_req     = issuing;
      bus.free_slots = DEPTH_C - count_q;
      bus.drained    = (count_q == '0) && (state_q != DRAIN_WAIT);
      bus.overflow   = overflow_q;
      if (issuing) begin
        bus.proc2mem_addr = wbAddr(entries_q[head_q]);
        bus.proc2mem_data = entries_q[head_q].line.data;
        if (bus.mem_grant) bus.proc2mem_command = BUS_STORE;
      end
    end
  end

  // Match each lookup's {tag, idx} against every valid entry
  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) begin
      hitVec[r] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        hitVec[r][e] = valid_q[e] && entries_q[e].line.valid && entries_q[e].line.dirty &&
                       (entries_q[e].line.tag == bus.rd_tag[r]) &&
                       (entries_q[e].idx == bus.rd_idx[r]);
      end
    end
  end

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rdSel
    vic_wb_buffer_age_select #(.DEPTH(DEPTH)) u_ageSelect (
      .hitVec_i (hitVec[r]),
      .head_i   (head_q),
      .hit_o    (selHit[r]),
      .sel_o    (selIdx[r])
    );
  end

  // Forward the youngest matching entry's data; nothing hits while disabled or in reset
  always_comb begin
    bus.rd_hit  = '0;
    bus.rd_data = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      if (!reset && bus.rd_en[r] && selHit[r]) begin
        bus.rd_hit[r]  = 1'b1;
        bus.rd_data[r] = entries_q[selIdx[r]].line.data;
      end
    end
  end

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Self-checking bench for vic_wb_buffer: stores are checked by a monitor
// against a queue of expected write-backs; status and lookups are checked
// directly by the stimulus process.
module tb_vic_wb_buffer;
  import vic_wb_buffer_pkg::*;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t expQ[$];

  vic_wb_buffer_if #(.DEPTH(4), .IN_PORTS(3), .RD_PORTS(2)) bus ();

  vic_wb_buffer #(.DEPTH(4), .IN_PORTS(3), .RD_PORTS(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hand model of the store address: tag above a 4-bit index above 3 zero bits
  function automatic logic [63:0] mkAddr(input logic [11:0] tag, input logic [3:0] idx);
    return (64'(tag) << 7) | (64'(idx) << 3);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Start a new cycle: clear evictions and set the memory-side response
  task automatic applyStimulus(input logic grant, input logic [3:0] resp);
    @(negedge clock);
    bus.evict_valid       = '0;
    bus.evict_line        = '0;
    bus.evict_idx         = '0;
    bus.mem_grant         = grant;
    bus.mem2proc_response = resp;
  endtask

  task automatic setPort(input int p, input logic dirty, input logic [3:0] idx,
                         input logic [11:0] tag, input logic [63:0] data, input bit expectStore);
    bus.evict_valid[p] = 1'b1;
    bus.evict_line[p]  = '{valid: 1'b1, dirty: dirty, tag: tag, data: data};
    bus.evict_idx[p]   = idx;
    if (expectStore) expQ.push_back('{addr: mkAddr(tag, idx), data: data});
  endtask

  task automatic waitEmpty(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (expQ.size() == 0) return;
      @(negedge clock);
      bus.evict_valid = '0;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got %0d pending stores, expected 0", expQ.size());
    end
  endtask

  // Store monitor: every STORE must match the oldest expected write-back; acknowledged ones retire it
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset && bus.proc2mem_command == BUS_STORE) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected store: got addr 0x%0h, expected no store", bus.proc2mem_addr);
        end else begin
          checkOutput("store addr", bus.proc2mem_addr, expQ[0].addr);
          checkOutput("store data", bus.proc2mem_data, expQ[0].data);
          if (bus.mem2proc_response != 4'd0) void'(expQ.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.evict_valid       = '0;
    bus.evict_line        = '0;
    bus.evict_idx         = '0;
    bus.rd_en             = 2'b11;
    bus.rd_idx            = '0;
    bus.rd_tag            = '0;
    bus.mem_grant         = 1'b1;
    bus.mem2proc_response = 4'd1;
    bus.drain             = 1'b0;

    // Reset values
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("reset command", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    checkOutput("reset wb_req", 64'(bus.wb_req), 64'd0);
    checkOutput("reset rd_hit", 64'(bus.rd_hit), 64'd0);
    checkOutput("reset free_slots", 64'(bus.free_slots), 64'd4);
    checkOutput("reset drained", 64'(bus.drained), 64'd1);
    checkOutput("reset overflow", 64'(bus.overflow), 64'd0);
    bus.rd_en = 2'b00;
    @(negedge clock);
    reset = 1'b0;

    // Single dirty eviction, acknowledged store
    applyStimulus(1'b1, 4'd3);
    setPort(0, 1'b1, 4'd5, 12'h012, 64'hAA, 1'b1);
    bus.rd_en[0] = 1'b1; bus.rd_idx[0] = 4'd5; bus.rd_tag[0] = 12'h012;
    #1;
    checkOutput("same-cycle enqueue invisible", 64'(bus.rd_hit[0]), 64'd0);
    checkOutput("t1 free before", 64'(bus.free_slots), 64'd4);
    applyStimulus(1'b1, 4'd3);
    #1;
    checkOutput("t1 free after push", 64'(bus.free_slots), 64'd3);
    checkOutput("t1 lookup hit", 64'(bus.rd_hit[0]), 64'd1);
    checkOutput("t1 lookup data", bus.rd_data[0], 64'hAA);
    applyStimulus(1'b1, 4'd3);
    #1;
    checkOutput("t1 store issued", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    checkOutput("t1 popped entry visible", 64'(bus.rd_hit[0]), 64'd1);
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t1 free after pop", 64'(bus.free_slots), 64'd4);
    checkOutput("t1 drained", 64'(bus.drained), 64'd1);
    checkOutput("t1 lookup after pop", 64'(bus.rd_hit[0]), 64'd0);
    checkOutput("t1 pending stores", 64'(expQ.size()), 64'd0);
    bus.rd_en = 2'b00;

    // Three evictions, port 1 clean, no grant
    applyStimulus(1'b0, 4'd0);
    setPort(0, 1'b1, 4'd1, 12'h021, 64'h100, 1'b1);
    setPort(1, 1'b0, 4'd2, 12'h022, 64'h200, 1'b0);
    setPort(2, 1'b1, 4'd3, 12'h023, 64'h300, 1'b1);
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t2 free_slots", 64'(bus.free_slots), 64'd2);
    setPort(0, 1'b1, 4'd4, 12'h024, 64'h400, 1'b1);
    bus.rd_en[1] = 1'b1; bus.rd_idx[1] = 4'd2; bus.rd_tag[1] = 12'h022;
    #1;
    checkOutput("t2 clean line not stored", 64'(bus.rd_hit[1]), 64'd0);
    bus.rd_en = 2'b00;

    // Full minus one: two candidates with a concurrent pop, only one fits
    applyStimulus(1'b1, 4'd1);
    setPort(0, 1'b1, 4'd6, 12'h026, 64'h600, 1'b1);
    setPort(1, 1'b1, 4'd7, 12'h027, 64'h700, 1'b0);
    #1;
    checkOutput("t3 free before", 64'(bus.free_slots), 64'd1);
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t3 count held", 64'(bus.free_slots), 64'd1);
    checkOutput("t3 overflow", 64'(bus.overflow), 64'd1);
    checkOutput("t3 wb_req", 64'(bus.wb_req), 64'd1);
    checkOutput("t3 no grant no command", 64'(bus.proc2mem_command), 64'(BUS_NONE));

    // Rejected four times, then accepted
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'd0);
      #1;
      checkOutput("t4 no pop on reject", 64'(bus.free_slots), 64'd1);
    end
    applyStimulus(1'b1, 4'd5);
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t4 pop on accept", 64'(bus.free_slots), 64'd2);
    applyStimulus(1'b1, 4'd1);
    waitEmpty(20);
    #1;
    checkOutput("t4 emptied", 64'(bus.free_slots), 64'd4);
    checkOutput("t4 overflow sticky", 64'(bus.overflow), 64'd1);

    // Duplicate address: youngest forwarded, both stored in order
    applyStimulus(1'b0, 4'd0);
    setPort(0, 1'b1, 4'd9, 12'h055, 64'h1, 1'b1);
    setPort(1, 1'b1, 4'd9, 12'h055, 64'h2, 1'b1);
    bus.rd_en = 2'b01; bus.rd_idx[0] = 4'd9; bus.rd_tag[0] = 12'h055;
    applyStimulus(1'b0, 4'd0);
    bus.rd_en = 2'b11; bus.rd_idx[1] = 4'd9; bus.rd_tag[1] = 12'h056;
    #1;
    checkOutput("t5 dup hit", 64'(bus.rd_hit[0]), 64'd1);
    checkOutput("t5 dup youngest data", bus.rd_data[0], 64'h2);
    checkOutput("t5 tag mismatch", 64'(bus.rd_hit[1]), 64'd0);
    bus.rd_en[1] = 1'b0; bus.rd_tag[1] = 12'h055;
    #1;
    checkOutput("t5 rd_en low", 64'(bus.rd_hit[1]), 64'd0);
    applyStimulus(1'b1, 4'd1);
    #1;
    checkOutput("t5 youngest while older pops", bus.rd_data[0], 64'h2);
    waitEmpty(20);
    #1;
    checkOutput("t5 miss after drain", 64'(bus.rd_hit[0]), 64'd0);
    bus.rd_en = 2'b00;

    // Reset mid-transaction discards contents and clears overflow
    applyStimulus(1'b0, 4'd0);
    setPort(0, 1'b1, 4'd10, 12'h04A, 64'h77, 1'b0);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b1, 4'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset command", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    checkOutput("mid reset overflow", 64'(bus.overflow), 64'd0);
    applyStimulus(1'b0, 4'd0);
    reset = 1'b0;
    bus.rd_en = 2'b01; bus.rd_idx[0] = 4'd10; bus.rd_tag[0] = 12'h04A;
    #1;
    checkOutput("post reset free", 64'(bus.free_slots), 64'd4);
    checkOutput("post reset overflow", 64'(bus.overflow), 64'd0);
    checkOutput("post reset lookup", 64'(bus.rd_hit[0]), 64'd0);
    bus.rd_en = 2'b00;

    // Wrap-around: push 4, pop 2, push 2 across the index wrap, then drain
    applyStimulus(1'b0, 4'd0);
    setPort(0, 1'b1, 4'd1, 12'h031, 64'hA1, 1'b1);
    setPort(1, 1'b1, 4'd2, 12'h032, 64'hB2, 1'b1);
    setPort(2, 1'b1, 4'd3, 12'h033, 64'hC3, 1'b1);
    applyStimulus(1'b0, 4'd0);
    setPort(0, 1'b1, 4'd4, 12'h034, 64'hD4, 1'b1);
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t6 full", 64'(bus.free_slots), 64'd0);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t6 after two pops", 64'(bus.free_slots), 64'd2);
    setPort(0, 1'b1, 4'd3, 12'h033, 64'hE5, 1'b1);
    setPort(1, 1'b1, 4'd5, 12'h035, 64'hF6, 1'b1);
    applyStimulus(1'b0, 4'd0);
    bus.rd_en = 2'b01; bus.rd_idx[0] = 4'd3; bus.rd_tag[0] = 12'h033;
    #1;
    checkOutput("t6 full after wrap", 64'(bus.free_slots), 64'd0);
    checkOutput("t6 no overflow", 64'(bus.overflow), 64'd0);
    checkOutput("t6 wrapped youngest hit", 64'(bus.rd_hit[0]), 64'd1);
    checkOutput("t6 wrapped youngest data", bus.rd_data[0], 64'hE5);
    bus.rd_en = 2'b00;
    bus.drain = 1'b1;
    applyStimulus(1'b1, 4'd1);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (expQ.size() == 0) break;
      checkOutput("t6 drained low while pending", 64'(bus.drained), 64'd0);
      @(negedge clock);
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL t6 drain timeout: got %0d pending stores, expected 0", expQ.size());
    end
    bus.drain = 1'b0;
    applyStimulus(1'b0, 4'd0);
    #1;
    checkOutput("t6 drained after release", 64'(bus.drained), 64'd1);
    checkOutput("t6 free at end", 64'(bus.free_slots), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
